riscv_core_mux_nto1_pipe: RTL and testbench
===========================================

RISCV_CORE_MUX_NTO1_PIPE -- requirements
Module: riscv_core_mux_nto1_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of each data lane.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, meaning the number of selectable lanes (legal range 2..16).
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(NUM_INPUTS), meaning the select width (derived value, minimum 1).
REQ-004 SHALL have parameter DEFAULT_VALUE, default 0, meaning the data value emitted for an out-of-range select.
REQ-005 SHALL have one clock and a synchronous active-low reset, named as the codebase names them: i_clk and i_rst_n.
REQ-006 i_clk  input  1  rising-edge clock.
REQ-007 i_rst_n  input  1  synchronous active-low reset.
REQ-008 i_inputs  input  NUM_INPUTS*DATA_WIDTH  flattened lanes; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 i_sel  input  SEL_WIDTH  binary lane select, sampled with i_valid.
REQ-010 i_valid  input  1  upstream beat valid.
REQ-011 o_ready  output  1  module can accept a beat.
REQ-012 o_mux_out  output  DATA_WIDTH  registered selected data.
REQ-013 o_valid  output  1  o_mux_out valid.
REQ-014 i_ready  input  1  downstream accepts the beat.
REQ-015 i_flush  input  1  synchronous discard of all held beats.
REQ-016 o_sel_err  output  1  current output beat was produced from an out-of-range select.

Function
REQ-017 A beat SHALL be accepted on a rising edge where i_valid && o_ready && !i_flush.
REQ-018 A beat SHALL be delivered on a rising edge where o_valid && i_ready.
REQ-019 The accepted data SHALL be lane i_sel when i_sel < NUM_INPUTS; otherwise it SHALL be DEFAULT_VALUE, and o_sel_err SHALL be 1 for that beat.
REQ-020 The block SHALL hold an output register (OUT) and one skid register (SKID); its state machine SHALL have the states EMPTY, ONE and FULL.
REQ-021 EMPTY: o_valid=0, o_ready=1; an accept loads OUT and moves to ONE.
REQ-022 ONE: o_valid=1, o_ready=1.
  - Accept with deliver: reload OUT, stay in ONE.
  - Accept without deliver: load SKID, move to FULL.
  - Deliver without accept: move to EMPTY.
REQ-023 FULL: o_valid=1, o_ready=0; a deliver moves SKID into OUT and moves to ONE.
REQ-024 Latency from accept to o_valid SHALL be 1 cycle in EMPTY; sustained throughput SHALL be 1 beat/cycle while i_ready=1.
REQ-025 o_ready SHALL be a registered signal (no combinational path from i_ready to o_ready).
REQ-026 Beats SHALL be delivered in acceptance order, with no loss or duplication.
REQ-027 o_mux_out and o_sel_err SHALL stay stable while o_valid=1 and i_ready=0.
REQ-028 i_flush=1 SHALL move the block to EMPTY on that edge, overriding any simultaneous accept or deliver; the input beat in that cycle is dropped, and o_ready=1 on the next cycle.
REQ-029 Data registers SHALL NOT change when no accept occurs.

Reset
REQ-030 When i_rst_n=0 at a rising edge, the block SHALL go to EMPTY with o_valid=0, o_ready=1, o_mux_out=0 and o_sel_err=0; SKID SHALL be cleared to 0.
REQ-031 Reset SHALL take priority over i_flush and all handshakes; a reset asserted mid-operation SHALL discard held beats.

Verification
REQ-032 Reset then one beat (DATA_WIDTH=32, NUM_INPUTS=4): lanes = {0x44, 0x33, 0x22, 0x11}, i_sel=2, i_valid for 1 cycle, i_ready=1 -> next cycle o_valid=1, o_mux_out=0x33, o_sel_err=0; the cycle after, o_valid=0.
REQ-033 Backpressure: i_ready=0, send beats A=0xA, B=0xB, C=0xC -> A is held in OUT, B in SKID, o_ready=0 after B, C is not accepted; raise i_ready -> outputs A then B in consecutive cycles, and o_ready returns to 1.
REQ-034 Out-of-range select (NUM_INPUTS=3, SEL_WIDTH=2): i_sel=3, DEFAULT_VALUE=0xDEAD -> o_mux_out=0xDEAD, o_sel_err=1.
REQ-035 Flush in FULL with i_valid=1 in the same cycle -> next cycle o_valid=0, o_ready=1, the input beat is dropped, and no stale beat appears afterwards.
REQ-036 Streaming: i_valid=1 and i_ready=1 for 16 cycles with i_sel cycling 0..3 -> 16 beats out in order, 1 per cycle, first beat 1 cycle after the first accept.
REQ-037 Reset in FULL: i_rst_n=0 for 1 cycle -> o_valid=0, o_ready=1, o_mux_out=0; later beats are unaffected.

Source files
------------

// File: rtl/riscv_core_mux_nto1_pipe.sv
// N-to-1 lane mux feeding a two-entry (OUT + SKID) valid/ready output stage.
// o_ready and o_valid come straight from flops; i_flush and reset drop every held beat.
//
// state | meaning
// EMPTY | nothing held, o_valid=0, o_ready=1
// ONE   | beat in OUT, o_valid=1, o_ready=1
// FULL  | beats in OUT and SKID, o_valid=1, o_ready=0
module riscv_core_mux_nto1_pipe #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_INPUTS    = 4,
  parameter int                    SEL_WIDTH     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_inputs,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_mux_out,
  output logic                             o_valid,
  input  logic                             i_ready,
  input  logic                             i_flush,
  output logic                             o_sel_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, ready_q;
  logic [DATA_WIDTH-1:0] out_q, skid_q;
  logic                  err_q, skid_err_q;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_err;
  logic                  accept, deliver;
  logic                  load_out_in, load_out_skid, load_skid;

  // Out-of-range selects fall through to DEFAULT_VALUE and flag an error.
  always_comb begin
    sel_data = DEFAULT_VALUE;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_sel == SEL_WIDTH'(k)) begin
        sel_data = i_inputs[k*DATA_WIDTH +: DATA_WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept  = i_valid && ready_q && !i_flush;
  assign deliver = valid_q && i_ready;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_out_in = 1'b1;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          load_out_skid = 1'b1;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any same-cycle handshake; held data is left in place but invalid.
    if (i_flush) begin
      state_d       = EMPTY;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= EMPTY;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      out_q      <= '0;
      err_q      <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      if (load_out_in) begin
        out_q <= sel_data;
        err_q <= sel_err;
      end else if (load_out_skid) begin
        out_q <= skid_q;
        err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_q     <= sel_data;
        skid_err_q <= sel_err;
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_ready   = ready_q;
  assign o_mux_out = out_q;
  assign o_sel_err = err_q;

endmodule

// File: tb/tb_riscv_core_mux_nto1_pipe.sv
// Directed bench: occupancy/scoreboard model for a 4-lane instance, plus a
// 3-lane instance for the out-of-range select path.
module tb_riscv_core_mux_nto1_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, valid, ready, flush;
  logic [1:0]   sel;
  logic [127:0] inputs;
  logic         o_ready, o_valid, o_sel_err;
  logic [31:0]  o_mux_out;

  logic [1:0]   sel3;
  logic         valid3;
  logic [95:0]  inputs3;
  logic         o_ready3, o_valid3, o_sel_err3;
  logic [31:0]  o_mux_out3;

  logic [31:0]  lane [4];
  logic [32:0]  sbq [$];
  int total = 0;
  int bad   = 0;

  riscv_core_mux_nto1_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inputs(inputs), .i_sel(sel),
    .i_valid(valid), .o_ready(o_ready), .o_mux_out(o_mux_out),
    .o_valid(o_valid), .i_ready(ready), .i_flush(flush), .o_sel_err(o_sel_err)
  );

  riscv_core_mux_nto1_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2),
                             .DEFAULT_VALUE(32'hDEAD)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_inputs(inputs3), .i_sel(sel3),
    .i_valid(valid3), .o_ready(o_ready3), .o_mux_out(o_mux_out3),
    .o_valid(o_valid3), .i_ready(1'b1), .i_flush(1'b0), .o_sel_err(o_sel_err3)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input logic [31:0] a, b, c, d);
    lane[0] = a; lane[1] = b; lane[2] = c; lane[3] = d;
    inputs  = {d, c, b, a};
  endtask

  // One clock: check occupancy, score handshakes at the edge, return 1 time unit after it.
  task automatic cyc();
    logic [32:0] e;
    bit acc, dlv;
    @(negedge clk);
    if (!rst_n) begin
      sbq.delete();
    end else begin
      chk("o_valid_occ", o_valid, sbq.size() != 0);
      chk("o_ready_occ", o_ready, sbq.size() < 2);
      acc = valid && (sbq.size() < 2);
      dlv = ready && (sbq.size() != 0);
      if (flush) begin
        sbq.delete();
      end else begin
        if (dlv) begin
          e = sbq.pop_front();
          chk("beat", {o_sel_err, o_mux_out}, e);
        end
        if (acc) sbq.push_back({1'b0, lane[sel]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; flush = 1'b0; sel = 2'd0;
    set_lanes(32'h0, 32'h0, 32'h0, 32'h0);
    sel3 = 2'd0; valid3 = 1'b0; inputs3 = {32'h3, 32'h2, 32'h1};
    cyc(); cyc();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_data", o_mux_out, 32'h0);
    chk("rst_err", o_sel_err, 1'b0);
    rst_n = 1'b1;
    cyc();

    // single beat, lane 2
    set_lanes(32'h11, 32'h22, 32'h33, 32'h44);
    sel = 2'd2; valid = 1'b1;
    cyc();
    valid = 1'b0;
    chk("one_valid", o_valid, 1'b1);
    chk("one_data", o_mux_out, 32'h33);
    chk("one_err", o_sel_err, 1'b0);
    cyc();
    chk("one_gone", o_valid, 1'b0);

    // backpressure: A to OUT, B to SKID, C refused
    ready = 1'b0; sel = 2'd0; valid = 1'b1;
    set_lanes(32'hA, 32'h0, 32'h0, 32'h0); cyc();
    set_lanes(32'hB, 32'h0, 32'h0, 32'h0); cyc();
    chk("bp_ready_full", o_ready, 1'b0);
    set_lanes(32'hC, 32'h0, 32'h0, 32'h0); cyc();
    valid = 1'b0;
    chk("bp_hold_a", o_mux_out, 32'hA);
    ready = 1'b1;
    cyc();
    chk("bp_b_next", o_mux_out, 32'hB);
    chk("bp_b_valid", o_valid, 1'b1);
    chk("bp_ready_back", o_ready, 1'b1);
    cyc();
    chk("bp_drained", o_valid, 1'b0);

    // flush while FULL with a beat offered
    ready = 1'b0; valid = 1'b1; sel = 2'd1;
    set_lanes(32'h0, 32'h101, 32'h0, 32'h0); cyc();
    set_lanes(32'h0, 32'h102, 32'h0, 32'h0); cyc();
    set_lanes(32'h0, 32'h103, 32'h0, 32'h0); flush = 1'b1; cyc();
    flush = 1'b0; valid = 1'b0;
    chk("fl_valid", o_valid, 1'b0);
    chk("fl_ready", o_ready, 1'b1);
    ready = 1'b1;
    cyc(); cyc();
    chk("fl_no_stale", o_valid, 1'b0);

    // streaming, 16 beats back to back
    for (int i = 0; i < 16; i++) begin
      set_lanes($urandom, $urandom, $urandom, $urandom);
      sel = 2'(i); valid = 1'b1;
      cyc();
      if (i == 0) chk("st_first", {o_valid, o_mux_out}, {1'b1, lane[0]});
    end
    valid = 1'b0;
    cyc(); cyc();
    chk("st_drained", o_valid, 1'b0);

    // reset while FULL
    ready = 1'b0; valid = 1'b1; sel = 2'd3;
    set_lanes(32'h0, 32'h0, 32'h0, 32'h301); cyc();
    set_lanes(32'h0, 32'h0, 32'h0, 32'h302); cyc();
    valid = 1'b0; rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    chk("rf_valid", o_valid, 1'b0);
    chk("rf_ready", o_ready, 1'b1);
    chk("rf_data", o_mux_out, 32'h0);
    ready = 1'b1; valid = 1'b1;
    set_lanes(32'h0, 32'h0, 32'h0, 32'h3F3); cyc();
    valid = 1'b0;
    chk("rf_after", o_mux_out, 32'h3F3);
    cyc(); cyc();

    // 3-lane instance: in-range then out-of-range select
    sel3 = 2'd1; valid3 = 1'b1;
    @(posedge clk); #1;
    chk("m3_data", {o_sel_err3, o_mux_out3}, {1'b0, 32'h2});
    sel3 = 2'd3;
    @(posedge clk); #1;
    valid3 = 1'b0;
    chk("m3_oor_valid", o_valid3, 1'b1);
    chk("m3_oor_data", o_mux_out3, 32'hDEAD);
    chk("m3_oor_err", o_sel_err3, 1'b1);
    @(posedge clk); #1;
    chk("m3_gone", o_valid3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
